adc_dac_scaler_ci: RTL and testbench
====================================

# adc_dac_scaler_ci

Multi-channel, pipelined ADC-to-DAC code scaler, attached to the Nios II as a multicycle custom instruction. It converts an ADC sample into a DAC code using a per-channel fixed-point gain and a signed offset, with round-half-up and clamping to the DAC range. Gain and offset for each channel are programmable at run time through the same instruction port. A sticky saturation counter is available for status reads. The block replaces the fixed ×51/1000, 12-to-8-bit conversion path.

## Interface
- ADC_W, 12, ADC sample width in bits; taken from dataa[ADC_W-1:0]
- DAC_W, 8, DAC code width in bits
- GAIN_W, 16, unsigned gain width in bits
- FRAC_BITS, 16, number of fractional bits in the gain
- NUM_CH, 4, number of channels (1..16)
- DEFAULT_GAIN, 3342, reset gain for every channel (≈ 51/1000 × 2^16)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- clk_en  in  1  custom-instruction clock enable; when low, all state holds
- start  in  1  one-cycle request strobe
- n  in  2  operation select: 0 CONVERT, 1 SET_GAIN, 2 SET_OFFSET, 3 STATUS
- dataa  in  32  operand A: ADC sample or configuration value
- datab  in  32  operand B: channel index in datab[3:0]; clear flag in datab[4] for STATUS
- done  out  1  one-cycle completion pulse
- result  out  32  operation result; valid while done is high, held until the next done

## Operation
- Reset values:
  - done = 0, result = 0.
  - All gains = DEFAULT_GAIN, all offsets = 0.
  - sat_cnt = 0, busy = 0, pipeline valid bits cleared.
- Request acceptance: a request is accepted when start=1 && clk_en=1 && busy=0.
  - start while busy is ignored: no done and no state change.
  - busy is high from acceptance until done.
- Channel index: ch = datab[3:0].
  - If ch ≥ NUM_CH: no register is written, result = 0, done still pulses at the normal latency.
- CONVERT (n=0):
  - adc = dataa[ADC_W-1:0], zero-extended; upper dataa bits are ignored.
  - p = adc × gain[ch], unsigned, ADC_W+GAIN_W bits.
  - r = (p + 2^(FRAC_BITS-1)) >> FRAC_BITS.
  - s = r + offset[ch], computed signed with enough width that it never overflows.
  - dac = clamp(s, 0, 2^DAC_W − 1).
  - result = {zeros, dac}.
  - If clamping is applied, sat_cnt increments, saturating at 0xFFFF.
- SET_GAIN (n=1): gain[ch] ← dataa[GAIN_W-1:0]. result = previous gain[ch], zero-extended.
- SET_OFFSET (n=2): offset[ch] ← dataa[DAC_W:0], signed (DAC_W+1 bits). result = previous offset[ch], sign-extended to 32 bits.
- STATUS (n=3):
  - result = {NUM_CH[15:0], sat_cnt}.
  - If datab[4]=1, sat_cnt clears after the read; the returned value is the pre-clear count.
  - When a saturating CONVERT completes on the same cycle as the clear, the clear wins.

## Timing
- Let E0 be the clk edge at which a request is accepted.
- CONVERT is a 3-stage pipeline:
  - E1: register adc, gain, and offset.
  - E2: register the rounded product r.
  - E3: register the clamped result; done=1 for the cycle following E3.
  - Latency: 3 cycles.
- SET_GAIN, SET_OFFSET, STATUS: the write or read occurs at E1, and done=1 for the cycle following E1. Latency: 1 cycle.
- Gain and offset are sampled at E1:
  - A SET issued back-to-back after a CONVERT cannot alter that CONVERT, because busy blocks the SET until the CONVERT is done.
- Earliest next acceptance: the edge on which done is high. Throughput is one operation per latency+1 cycles.
- clk_en low:
  - Pipeline stages, busy, and the counter freeze.
  - done stays low; if a done was due, it is deferred until clk_en returns high, and still lasts exactly one enabled cycle.
- Reset asserted mid-operation:
  - All registers return to their reset values immediately.
  - The pending done is discarded and never appears after reset deasserts.

## Test plan
- After reset, CONVERT ch0 with adc=4095 → done at E0+3, result=209. Then adc=1000 → 51; adc=0 → 0; sat_cnt stays 0.
- SET_GAIN ch1 to 65535 (result=3342), then CONVERT ch1 with adc=4095 → result=255. STATUS → result=0x0004_0001.
- SET_OFFSET ch2 to −10 (dataa=0x1F6), then CONVERT ch2 with adc=100 → r=5, result=0, sat_cnt increments. STATUS with datab[4]=1 returns the count; the next STATUS reads 0.
- CONVERT with ch=7 (NUM_CH=4) → done at E0+3, result=0. All gains and offsets are unchanged.
- Protocol checks:
  - Assert start while busy → that request gets no done.
  - Drop clk_en for 5 cycles mid-CONVERT → done is delayed by exactly 5 cycles and the result is correct.
- Assert reset at E1 of a CONVERT → done never pulses, result=0, and ch0 gain reads back 3342 via SET_GAIN.

Source files
------------

// File: rtl/adc_dac_scaler_ci_if.sv
// Custom-instruction request/response bundle for adc_dac_scaler_ci.
// The CPU side drives the request, the scaler answers with done/result.
interface adc_dac_scaler_ci_if;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, n, dataa, datab,
        input  done, result
    );

    modport slave (
        input  start, n, dataa, datab,
        output done, result
    );
endinterface

// File: rtl/adc_dac_scaler_ci.sv
// Per-channel gain/offset ADC-to-DAC code scaler, Nios II multicycle
// custom instruction: 3-cycle convert pipeline, 1-cycle config/status.
module adc_dac_scaler_ci #(
    parameter int ADC_W        = 12,
    parameter int DAC_W        = 8,
    parameter int GAIN_W       = 16,
    parameter int FRAC_BITS    = 16,
    parameter int NUM_CH       = 4,
    parameter int DEFAULT_GAIN = 3342
) (
    input logic                clk,
    input logic                reset,
    input logic                clk_en,
    adc_dac_scaler_ci_if.slave ci
);
    localparam int PW  = ADC_W + GAIN_W;
    localparam int RW  = PW + 1 - FRAC_BITS;
    localparam int OW  = DAC_W + 1;
    localparam int SW  = ((RW > OW) ? RW : OW) + 2;
    localparam int AW0 = (ADC_W > GAIN_W) ? ADC_W : GAIN_W;
    localparam int AW  = (AW0 > OW) ? AW0 : OW;

    localparam logic [PW:0]           HALF  = (PW + 1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [SW-1:0]  DMAX  = SW'((1 << DAC_W) - 1);
    localparam logic [15:0]           NCH16 = 16'(NUM_CH);
    localparam logic [GAIN_W-1:0]     GDEF  = GAIN_W'(DEFAULT_GAIN);

    typedef enum logic [1:0] {
        OP_CONV = 2'd0,
        OP_GAIN = 2'd1,
        OP_OFF  = 2'd2,
        OP_STAT = 2'd3
    } op_e;

    logic                     r_busy;
    logic                     r_v0;
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_done;
    logic                     r_clr;
    op_e                      r_op;
    logic [3:0]               r_ch;
    logic [AW-1:0]            r_a;
    logic [ADC_W-1:0]         r_adc;
    logic [GAIN_W-1:0]        r_g;
    logic signed [OW-1:0]     r_o;
    logic signed [OW-1:0]     r_o2;
    logic [RW-1:0]            r_r;
    logic [31:0]              r_result;
    logic [15:0]              r_sat;
    logic [GAIN_W-1:0]        r_gain [NUM_CH];
    logic signed [OW-1:0]     r_off  [NUM_CH];

    logic                     w_accept;
    logic                     w_ch_ok;
    logic [GAIN_W-1:0]        w_gain_rd;
    logic signed [OW-1:0]     w_off_rd;
    logic [PW-1:0]            w_p;
    logic [PW:0]              w_pr;
    logic signed [SW-1:0]     w_s;
    logic [DAC_W-1:0]         w_dac;
    logic                     w_clamp;
    logic                     w_clr;
    logic                     w_unused;

    assign w_accept = ci.start & clk_en & ~r_busy;
    assign w_ch_ok  = ({28'd0, r_ch} < 32'(NUM_CH));

    // Out-of-range channels match nothing and read back as zero.
    always_comb begin
        w_gain_rd = '0;
        w_off_rd  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch == 4'(i)) begin
                w_gain_rd = r_gain[i];
                w_off_rd  = r_off[i];
            end
        end
    end

    assign w_p  = {{GAIN_W{1'b0}}, r_adc} * {{ADC_W{1'b0}}, r_g};
    assign w_pr = {1'b0, w_p} + HALF;
    assign w_s  = $signed({{(SW - RW){1'b0}}, r_r})
                + $signed({{(SW - OW){r_o2[OW-1]}}, r_o2});

    always_comb begin
        w_clamp = 1'b0;
        w_dac   = w_s[DAC_W-1:0];
        if (w_s[SW-1]) begin
            w_clamp = 1'b1;
            w_dac   = '0;
        end else if (w_s > DMAX) begin
            w_clamp = 1'b1;
            w_dac   = '1;
        end
    end

    assign w_clr    = r_v0 && (r_op == OP_STAT) && w_ch_ok && r_clr;
    assign w_unused = ^{ci.dataa[31:AW], ci.datab[31:5],
                        w_pr[FRAC_BITS-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_done   <= 1'b0;
            r_clr    <= 1'b0;
            r_op     <= OP_CONV;
            r_ch     <= '0;
            r_a      <= '0;
            r_adc    <= '0;
            r_g      <= '0;
            r_o      <= '0;
            r_o2     <= '0;
            r_r      <= '0;
            r_result <= '0;
            r_sat    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_gain[i] <= GDEF;
                r_off[i]  <= '0;
            end
        end else if (clk_en) begin
            r_done <= 1'b0;
            r_v0   <= w_accept;
            r_v1   <= r_v0 && (r_op == OP_CONV);
            r_v2   <= r_v1;

            if (w_accept) begin
                r_busy <= 1'b1;
                r_op   <= op_e'(ci.n);
                r_ch   <= ci.datab[3:0];
                r_a    <= ci.dataa[AW-1:0];
                r_clr  <= ci.datab[4];
            end

            if (r_v0) begin
                unique case (r_op)
                    OP_CONV: begin
                        r_adc <= r_a[ADC_W-1:0];
                        r_g   <= w_gain_rd;
                        r_o   <= w_off_rd;
                    end
                    OP_GAIN: begin
                        r_result <= {{(32 - GAIN_W){1'b0}}, w_gain_rd};
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    OP_OFF: begin
                        r_result <= {{(32 - OW){w_off_rd[OW-1]}}, w_off_rd};
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    OP_STAT: begin
                        r_result <= w_ch_ok ? {NCH16, r_sat} : '0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                endcase
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (r_v0 && r_ch == 4'(i)) begin
                    if (r_op == OP_GAIN) r_gain[i] <= r_a[GAIN_W-1:0];
                    if (r_op == OP_OFF)  r_off[i]  <= $signed(r_a[OW-1:0]);
                end
            end

            if (r_v1) begin
                r_r  <= w_pr[PW:FRAC_BITS];
                r_o2 <= r_o;
            end

            if (r_v2) begin
                r_result <= {{(32 - DAC_W){1'b0}}, w_dac};
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
            end

            // A clear on the same edge as a saturating convert wins.
            if (w_clr)
                r_sat <= '0;
            else if (r_v2 && w_clamp && r_sat != 16'hFFFF)
                r_sat <= r_sat + 16'd1;
        end
    end

    assign ci.done   = r_done & clk_en;
    assign ci.result = r_result;
endmodule

// File: tb/tb_adc_dac_scaler_ci.sv
// Scoreboard bench for adc_dac_scaler_ci: a plain-arithmetic model
// predicts each response; a monitor thread pops and compares on done.
module tb_adc_dac_scaler_ci;
    localparam int NCH = 4;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;
    exp_t sb[$];

    int   m_gain [NCH];
    int   m_off  [NCH];
    int   m_sat;

    adc_dac_scaler_ci_if ci();

    adc_dac_scaler_ci dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .ci     (ci)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_gain[i] = 3342;
            m_off[i]  = 0;
        end
        m_sat = 0;
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] exp);
        int     ch;
        longint s;
        ch  = int'(b[3:0]);
        exp = 32'd0;
        if (ch < NCH) begin
            case (op)
                2'd0: begin
                    s = (longint'(a[11:0]) * longint'(m_gain[ch]) + 32768)
                        / 65536 + longint'(m_off[ch]);
                    if (s < 0 || s > 255) begin
                        if (m_sat < 65535) m_sat++;
                    end
                    if (s < 0) s = 0;
                    if (s > 255) s = 255;
                    exp = 32'(s);
                end
                2'd1: begin
                    exp = 32'(m_gain[ch]);
                    m_gain[ch] = int'(a[15:0]);
                end
                2'd2: begin
                    exp = 32'(m_off[ch]);
                    m_off[ch] = int'($signed(a[8:0]));
                end
                default: begin
                    exp = {16'(NCH), 16'(m_sat)};
                    if (b[4]) m_sat = 0;
                end
            endcase
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic push(input logic [31:0] e, input int lat);
        exp_t x;
        x.res = e;
        x.due = cyc + 1 + lat;
        sb.push_back(x);
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        ci.start = 1'b1;
        ci.n     = op;
        ci.dataa = a;
        ci.datab = b;
        @(posedge clk);
        #1 ci.start = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] e;
        int          lat;
        lat = (op == 2'd0) ? 3 : 1;
        model(op, a, b, e);
        push(e, lat);
        drive(op, a, b);
        repeat (lat) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        while (!stim_done) begin
            @(negedge clk);
            if (ci.done === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: result %h at cyc %0d",
                             ci.result, cyc);
                end else begin
                    e = sb.pop_front();
                    if (ci.result !== e.res || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL done_result: got %h at cyc %0d, want %h at cyc %0d",
                                 ci.result, cyc, e.res, e.due);
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        logic [31:0] e;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;

        reset    = 1'b1;
        clk_en   = 1'b1;
        ci.start = 1'b0;
        ci.n     = 2'd0;
        ci.dataa = '0;
        ci.datab = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 32'(ci.done), 32'd0);
        check("reset_result", ci.result, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op(2'd0, 32'd4095, 32'd0);
        do_op(2'd0, 32'hABCD_F3E8, 32'd0);
        do_op(2'd0, 32'd0, 32'd0);
        do_op(2'd3, 32'd0, 32'd0);

        do_op(2'd1, 32'd65535, 32'd1);
        do_op(2'd0, 32'd4095, 32'd1);
        do_op(2'd3, 32'd0, 32'd0);

        // Start pulse while a convert is in flight must be dropped.
        model(2'd0, 32'd4095, 32'd1, e);
        push(e, 3);
        drive(2'd0, 32'd4095, 32'd1);
        ci.start = 1'b1;
        ci.n     = 2'd3;
        ci.dataa = '0;
        ci.datab = 32'h10;
        @(posedge clk);
        #1 ci.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_op(2'd3, 32'd0, 32'd0);

        do_op(2'd2, 32'h1F6, 32'd2);
        do_op(2'd0, 32'd100, 32'd2);
        do_op(2'd3, 32'd0, 32'h10);
        do_op(2'd3, 32'd0, 32'd0);

        do_op(2'd0, 32'd4095, 32'd7);
        do_op(2'd1, 32'd1234, 32'd7);
        do_op(2'd2, 32'h0FF, 32'd9);
        for (int i = 0; i < NCH; i++) begin
            do_op(2'd1, 32'(m_gain[i]), 32'(i));
            do_op(2'd2, 32'(m_off[i]), 32'(i));
        end

        // Clock-enable stall of 5 cycles after E1.
        model(2'd0, 32'd2000, 32'd0, e);
        push(e, 8);
        drive(2'd0, 32'd2000, 32'd0);
        @(posedge clk);
        #1 clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1 clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset during a convert: no done may follow.
        drive(2'd0, 32'd4095, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_result", ci.result, 32'd0);
        do_op(2'd1, 32'd3342, 32'd0);

        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (op == 2'd1 && $urandom_range(0, 1) == 1)
                a = 32'($urandom_range(0, 8000));
            b      = $urandom;
            b[3:0] = 4'($urandom_range(0, 5));
            b[4]   = ($urandom_range(0, 3) == 0);
            do_op(op, a, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        do_op(2'd3, 32'd0, 32'd0);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        stim_done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
